// File: rtl/div_iter_pkg.sv
// Shared constants, state encoding and small arithmetic helpers for the
// iterative restoring divider.
package div_iter_pkg;

  localparam int DATA_W = 32;

  // Handshake encodings used by the EX stage and the divider
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic [DATA_W-1:0] ZeroWord = '0;

  typedef enum logic [2:0] {
    DivFree   = 3'b000,
    DivByZero = 3'b001,
    DivBusy   = 3'b010,
    DivEnd    = 3'b011,
    DivFix    = 3'b100
  } div_state_e;

  // Two's complement negation, modulo 2^DATA_W
  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return ZeroWord - v;
  endfunction

  // Conditional negation: magnitude extraction and final sign fix-up
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic neg);
    return neg ? negate(v) : v;
  endfunction

endpackage

// File: rtl/div_iter_if.sv
// Divide handshake between the EX stage (master) and the divider (slave).
interface div_iter_if;
  import div_iter_pkg::*;

  logic                signed_div_i;
  logic [DATA_W-1:0]   opdata1_i;
  logic [DATA_W-1:0]   opdata2_i;
  logic                start_i;
  logic                annul_i;
  logic [2*DATA_W-1:0] result_o;
  logic                ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div_iter_step.sv
// One combinational restoring-division iteration on the magnitudes:
// shift {rem, quo} left, try subtracting the divisor, keep it if no borrow.
module div_iter_step
  import div_iter_pkg::*;
(
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] dvsr_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  // The partial remainder is always below the divisor, so the shifted value
  // fits in DATA_W+1 bits and the top bit of the trial is the borrow.
  assign shifted = {rem_i, quo_i[DATA_W-1]};
  assign trial   = shifted - {1'b0, dvsr_i};
  assign rem_o   = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
  assign quo_o   = {quo_i[DATA_W-2:0], ~trial[DATA_W]};

endmodule

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider responding to the EX-stage divide
// handshake. Produces {remainder, quotient} for signed and unsigned divides.
module div_iter
  import div_iter_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  div_iter_if.slave  bus
);

  div_state_e          state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dvsr_q, dvsr_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic [2*DATA_W-1:0] result_q, result_d;

  logic                s1, s2;
  logic [DATA_W-1:0]   abs1, abs2;
  logic [DATA_W-1:0]   step_rem, step_quo;

  assign s1   = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
  assign s2   = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
  assign abs1 = cond_neg(bus.opdata1_i, s1);
  assign abs2 = cond_neg(bus.opdata2_i, s2);

  div_iter_step u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  // State and datapath registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  // Next-state and datapath: accept, 32 restoring steps, sign fix, hold
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    unique case (state_q)
      DivFree: begin
        if (bus.start_i == DivStart && !bus.annul_i) begin
          qneg_d = s1 ^ s2;
          rneg_d = s1;
          rem_d  = ZeroWord;
          cnt_d  = '0;
          dvsr_d = abs2;
          if (bus.opdata2_i == ZeroWord) begin
            // Divide-by-zero keeps the raw dividend for the result
            quo_d   = bus.opdata1_i;
            state_d = DivByZero;
          end else begin
            quo_d   = abs1;
            state_d = DivBusy;
          end
        end
      end

      DivBusy: begin
        if (bus.annul_i) begin
          state_d  = DivFree;
          result_d = '0;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = DivFix;
          end
        end
      end

      DivFix: begin
        if (bus.annul_i) begin
          state_d  = DivFree;
          result_d = '0;
        end else begin
          result_d = {cond_neg(rem_q, rneg_q), cond_neg(quo_q, qneg_q)};
          state_d  = DivEnd;
        end
      end

      DivByZero: begin
        if (bus.annul_i) begin
          state_d  = DivFree;
          result_d = '0;
        end else begin
          result_d = {quo_q, ~ZeroWord};
          state_d  = DivEnd;
        end
      end

      DivEnd: begin
        if (bus.annul_i || bus.start_i == DivStop) begin
          state_d  = DivFree;
          result_d = '0;
        end
      end

      default: begin
        state_d  = DivFree;
        result_d = '0;
      end
    endcase
  end

  assign bus.ready_o  = (state_q == DivEnd) ? DivResultReady : DivResultNotReady;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: a cycle-level behavioural model built on
// plain / and % is compared against the DUT outputs on every falling edge.
module tb_div_iter;

  logic clk;
  logic resetn;
  int   nVec;
  int   nErr;
  bit   checkOn;

  div_iter_if bus ();

  div_iter dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result straight from the arithmetic definition
  function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    logic        na, nb;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    na = sgn && a[31];
    nb = sgn && b[31];
    ma = na ? 32'd0 - a : a;
    mb = nb ? 32'd0 - b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (na ^ nb) q = 32'd0 - q;
    if (na)      r = 32'd0 - r;
    return {r, q};
  endfunction

  task automatic checkOutput(input string nm, input logic [63:0] got,
                             input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Behavioural model: an operation in flight counts down edges to its result
  bit          mActive, mReady;
  int          mLeft;
  logic [63:0] mResult, mPending;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mActive <= 1'b0;
      mReady  <= 1'b0;
      mLeft   <= 0;
      mResult <= '0;
      mPending <= '0;
    end else if (mActive) begin
      if (bus.annul_i) begin
        mActive <= 1'b0;
      end else if (mLeft == 1) begin
        mActive <= 1'b0;
        mReady  <= 1'b1;
        mResult <= mPending;
      end else begin
        mLeft <= mLeft - 1;
      end
    end else if (mReady) begin
      if (bus.annul_i || !bus.start_i) begin
        mReady  <= 1'b0;
        mResult <= '0;
      end
    end else if (bus.start_i && !bus.annul_i) begin
      mActive  <= 1'b1;
      mLeft    <= (bus.opdata2_i == 32'd0) ? 1 : 33;
      mPending <= refDiv(bus.signed_div_i, bus.opdata1_i, bus.opdata2_i);
    end
  end

  // Per-cycle comparison of DUT against the model
  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("ready_cycle", {63'd0, bus.ready_o}, {63'd0, mReady});
      checkOutput("result_cycle", bus.result_o, mResult);
    end
  end

  // Start an operation and wait (bounded) for ready; optionally scramble
  // the operands after the accept edge
  task automatic applyStimulus(input logic sgn, input logic [31:0] a,
                               input logic [31:0] b, input bit scramble,
                               output logic [63:0] res, output int lat);
    bit ok;
    @(negedge clk);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    lat = 0;
    ok  = 1'b0;
    while (lat < 60 && !ok) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.ready_o) ok = 1'b1;
      else if (scramble) begin
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = 1'($urandom_range(0, 1));
      end
    end
    checkOutput("ready_timeout", {63'd0, ok}, 64'd1);
    res = bus.result_o;
  endtask

  task automatic releaseStart(input int hold);
    repeat (hold) @(negedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 20));
      3:       return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] res;
    int          lat;
    bit          sawReady;
    logic        sgn;
    logic [31:0] a, b;

    nVec = 0;
    nErr = 0;
    checkOn = 1'b0;
    resetn = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    #2;
    checkOutput("reset_ready", {63'd0, bus.ready_o}, 64'd0);
    checkOutput("reset_result", bus.result_o, 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    checkOn = 1'b1;

    // Hand-computed values pinning the reference model
    checkOutput("model_100_7", refDiv(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    checkOutput("model_m7_2s", refDiv(1'b1, 32'hFFFF_FFF9, 32'd2),
                {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    checkOutput("model_ovf", refDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF),
                {32'h0, 32'h8000_0000});
    checkOutput("model_div0", refDiv(1'b1, 32'd5, 32'd0), {32'd5, 32'hFFFF_FFFF});

    $display("[TB] directed divides");
    applyStimulus(1'b0, 32'd100, 32'd7, 1'b0, res, lat);
    checkOutput("u100_7", res, {32'd2, 32'd14});
    checkOutput("u100_7_latency", 64'(lat), 64'd34);
    releaseStart(0);

    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, res, lat);
    checkOutput("s_m7_2", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    releaseStart(0);
    applyStimulus(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, res, lat);
    checkOutput("u_m7_2", res, {32'd1, 32'h7FFF_FFFC});
    releaseStart(0);

    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, res, lat);
    checkOutput("s_overflow", res, {32'h0, 32'h8000_0000});
    releaseStart(0);

    applyStimulus(1'b0, 32'd5, 32'd0, 1'b0, res, lat);
    checkOutput("u5_0", res, {32'd5, 32'hFFFF_FFFF});
    checkOutput("u5_0_latency", 64'(lat), 64'd2);
    releaseStart(0);
    applyStimulus(1'b1, 32'd5, 32'd0, 1'b0, res, lat);
    checkOutput("s5_0", res, {32'd5, 32'hFFFF_FFFF});
    checkOutput("s5_0_latency", 64'(lat), 64'd2);
    releaseStart(0);

    $display("[TB] annul during step 10, then restart");
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    bus.annul_i = 1'b0;
    sawReady = 1'b0;
    repeat (40) begin
      @(negedge clk);
      sawReady |= bus.ready_o;
    end
    checkOutput("annul_no_ready", {63'd0, sawReady}, 64'd0);
    applyStimulus(1'b0, 32'd9, 32'd3, 1'b0, res, lat);
    checkOutput("u9_3", res, {32'd0, 32'd3});
    releaseStart(0);

    $display("[TB] annul beats start in idle");
    @(negedge clk);
    bus.opdata1_i = 32'd50;
    bus.opdata2_i = 32'd5;
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    sawReady = 1'b0;
    repeat (40) begin
      @(negedge clk);
      sawReady |= bus.ready_o;
    end
    checkOutput("idle_annul_no_ready", {63'd0, sawReady}, 64'd0);

    $display("[TB] hold start in done");
    applyStimulus(1'b0, 32'd100, 32'd7, 1'b0, res, lat);
    repeat (5) begin
      @(negedge clk);
      checkOutput("hold_result", bus.result_o, {32'd2, 32'd14});
      checkOutput("hold_ready", {63'd0, bus.ready_o}, 64'd1);
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    checkOutput("drop_result", bus.result_o, 64'd0);
    checkOutput("drop_ready", {63'd0, bus.ready_o}, 64'd0);

    $display("[TB] asynchronous reset");
    @(negedge clk);
    bus.start_i = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("areset_busy_ready", {63'd0, bus.ready_o}, 64'd0);
    checkOutput("areset_busy_result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0, res, lat);
    checkOutput("s_m100_7", res, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("areset_done_ready", {63'd0, bus.ready_o}, 64'd0);
    checkOutput("areset_done_result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    $display("[TB] randomized divides");
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = pickOperand();
      b   = ($urandom_range(0, 7) == 0) ? 32'd0 : pickOperand();
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        repeat ($urandom_range(1, 35)) @(negedge clk);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(negedge clk);
        bus.annul_i = 1'b0;
        @(negedge clk);
      end else begin
        applyStimulus(sgn, a, b, 1'b1, res, lat);
        checkOutput("rand_result", res, refDiv(sgn, a, b));
        releaseStart($urandom_range(0, 3));
      end
    end

    repeat (2) @(negedge clk);
    checkOn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
